// File: rtl/serial_to_parallel_converter_if.sv
// Bundle of the serial input, the parallel output handshake and the status
// outputs of the serial-to-parallel converter.
// The slave modport is the converter itself. The master modport is the
// surrounding logic that feeds bits in and consumes words.
interface serial_to_parallel_converter_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  logic                     serial_i;
  logic                     valid_i;
  logic [WIDTH-1:0]         parallel_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     overrun_o;
  logic                     abort_o;
  logic [$clog2(DEPTH):0]   level_o;

  modport slave (
    input  serial_i, valid_i, ready_i,
    output parallel_o, valid_o, overrun_o, abort_o, level_o
  );

  modport master (
    output serial_i, valid_i, ready_i,
    input  parallel_o, valid_o, overrun_o, abort_o, level_o
  );
endinterface

// File: rtl/serial_to_parallel_converter.sv
// Reassembles an LSB-first serial stream into WIDTH-bit words.
// Completed words go into a small show-ahead FIFO that is drained with a
// valid/ready handshake.
// A partial word that stalls for TIMEOUT idle cycles is thrown away.
// A completed word that finds the FIFO full (and no pop that cycle) is dropped
// and flagged.
module serial_to_parallel_converter #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  serial_to_parallel_converter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH);
  localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_bitCount;
  logic [CW-1:0]   w_nextBitCount;
  logic [GW-1:0]   r_gap;
  logic [GW-1:0]   w_nextGap;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_nextShreg;
  logic [WIDTH-1:0] w_shifted;
  logic            w_wordDone;
  logic            w_abort;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]     r_wrPtr;
  logic [AW:0]     r_rdPtr;
  logic [LW-1:0]   r_level;
  logic            r_overrun;
  logic            r_abort;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_overrun;

  // The new bit always enters at the top, so the first bit ends up in bit 0.
  assign w_shifted = {bus.serial_i, r_shreg[WIDTH-1:1]};

  // Next-state and datapath decisions for word assembly and gap timeout.
  always_comb begin
    w_nextState    = r_state;
    w_nextBitCount = r_bitCount;
    w_nextGap      = r_gap;
    w_nextShreg    = r_shreg;
    w_wordDone     = 1'b0;
    w_abort        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nextGap = '0;
        if (bus.valid_i) begin
          w_nextShreg    = w_shifted;
          w_nextBitCount = CW'(1);
          w_nextState    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.valid_i) begin
          w_nextShreg = w_shifted;
          w_nextGap   = '0;
          if (r_bitCount == CW'(WIDTH - 1)) begin
            w_wordDone     = 1'b1;
            w_nextBitCount = '0;
            w_nextState    = ST_IDLE;
          end else begin
            w_nextBitCount = r_bitCount + CW'(1);
          end
        end else if (TIMEOUT != 0) begin
          if (r_gap == GW'(TIMEOUT - 1)) begin
            w_abort        = 1'b1;
            w_nextBitCount = '0;
            w_nextGap      = '0;
            w_nextState    = ST_IDLE;
          end else begin
            w_nextGap = r_gap + GW'(1);
          end
        end
      end
      default: begin
        w_nextState    = ST_IDLE;
        w_nextBitCount = '0;
        w_nextGap      = '0;
      end
    endcase
  end

  // Register the assembly state; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bitCount <= '0;
      r_gap      <= '0;
      r_shreg    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_bitCount <= w_nextBitCount;
      r_gap      <= w_nextGap;
      r_shreg    <= w_nextShreg;
    end
  end

  // The extra pointer bit tells full from empty when the indices match.
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a word.
  assign w_empty   = (r_wrPtr == r_rdPtr);
  assign w_full    = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop     = !w_empty && bus.ready_i;
  assign w_push    = w_wordDone && (!w_full || w_pop);
  assign w_overrun = w_wordDone && w_full && !w_pop;

  // Store a completed word at the write slot; storage needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= w_nextShreg;
    end
  end

  // Pointers, occupancy and the one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + (AW+1)'(1);
      end
      r_level   <= r_level + LW'(w_push) - LW'(w_pop);
      r_overrun <= w_overrun;
      r_abort   <= w_abort;
    end
  end

  assign bus.valid_o    = !w_empty;
  assign bus.parallel_o = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign bus.level_o    = r_level;
  assign bus.overrun_o  = r_overrun;
  assign bus.abort_o    = r_abort;
endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Testbench for the serial-to-parallel converter.
// A queue-based reference model tracks the partial word, the gap count and
// the FIFO contents, and every cycle is compared against the DUT.
module tb_serial_to_parallel_converter;
  localparam int WIDTH   = 4;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;

  int passCount  = 0;
  int totalCount = 0;

  int partialBits[$];
  int fifoQ[$];
  int gapCount;
  bit expOverrun;
  bit expAbort;

  serial_to_parallel_converter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  serial_to_parallel_converter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    partialBits.delete();
    fifoQ.delete();
    gapCount   = 0;
    expOverrun = 1'b0;
    expAbort   = 1'b0;
  endtask

  task automatic compareAll();
    checkOutput("valid_o", 32'(bus.valid_o), 32'(fifoQ.size() > 0));
    if (fifoQ.size() > 0)
      checkOutput("parallel_o", 32'(bus.parallel_o), 32'(fifoQ[0]));
    else
      checkOutput("parallel_o", 32'(bus.parallel_o), 32'd0);
    checkOutput("level_o", 32'(bus.level_o), 32'(fifoQ.size()));
    checkOutput("overrun_o", 32'(bus.overrun_o), 32'(expOverrun));
    checkOutput("abort_o", 32'(bus.abort_o), 32'(expAbort));
  endtask

  // Drive one cycle, advance the reference model over the edge, then compare.
  task automatic applyStimulus(input bit s, input bit v, input bit r);
    bit pop;
    bit full;
    int word;
    bus.serial_i = s;
    bus.valid_i  = v;
    bus.ready_i  = r;
    @(posedge clk);
    pop  = (fifoQ.size() > 0) && r;
    full = (fifoQ.size() == DEPTH);
    expOverrun = 1'b0;
    expAbort   = 1'b0;
    if (pop) void'(fifoQ.pop_front());
    if (v) begin
      partialBits.push_back(int'(s));
      gapCount = 0;
      if (partialBits.size() == WIDTH) begin
        word = 0;
        foreach (partialBits[i]) word += partialBits[i] << i;
        partialBits.delete();
        if (!full || pop) fifoQ.push_back(word);
        else expOverrun = 1'b1;
      end
    end else if (partialBits.size() > 0) begin
      gapCount++;
      if (gapCount == TIMEOUT) begin
        partialBits.delete();
        gapCount = 0;
        expAbort = 1'b1;
      end
    end
    #1;
    compareAll();
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w, input bit r);
    for (int i = 0; i < WIDTH; i++) applyStimulus(w[i], 1'b1, r);
  endtask

  task automatic idleCycles(input int n, input bit r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, r);
  endtask

  // Directed scenarios followed by a randomized stream.
  initial begin
    reset = 1'b1;
    bus.serial_i = 1'b0;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("reset_parallel", 32'(bus.parallel_o), 32'd0);
    checkOutput("reset_level", 32'(bus.level_o), 32'd0);
    checkOutput("reset_overrun", 32'(bus.overrun_o), 32'd0);
    checkOutput("reset_abort", 32'(bus.abort_o), 32'd0);

    // Single word 1,0,1,1 -> D.
    sendWord(4'hD, 1'b1);
    checkOutput("single_word", 32'(bus.parallel_o), 32'hD);
    checkOutput("single_valid", 32'(bus.valid_o), 32'd1);
    idleCycles(1, 1'b1);
    checkOutput("single_drained", 32'(bus.valid_o), 32'd0);

    // Back-to-back words with the consumer always ready.
    sendWord(4'hD, 1'b1);
    checkOutput("b2b_first", 32'(bus.parallel_o), 32'hD);
    sendWord(4'h3, 1'b1);
    checkOutput("b2b_second", 32'(bus.parallel_o), 32'h3);
    sendWord(4'hA, 1'b1);
    checkOutput("b2b_third", 32'(bus.parallel_o), 32'hA);
    idleCycles(2, 1'b1);

    // Fill the FIFO with the consumer stalled, then overrun it.
    sendWord(4'h1, 1'b0);
    sendWord(4'h2, 1'b0);
    sendWord(4'h3, 1'b0);
    checkOutput("ovr_level", 32'(bus.level_o), 32'd2);
    checkOutput("ovr_pulse", 32'(bus.overrun_o), 32'd1);
    idleCycles(1, 1'b0);
    checkOutput("ovr_pulse_end", 32'(bus.overrun_o), 32'd0);
    checkOutput("stall_hold", 32'(bus.parallel_o), 32'h1);
    idleCycles(2, 1'b0);
    idleCycles(1, 1'b1);
    checkOutput("pop_second", 32'(bus.parallel_o), 32'h2);
    idleCycles(1, 1'b1);
    checkOutput("pop_empty", 32'(bus.valid_o), 32'd0);

    // Timeout after two bits, then a clean word.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(7, 1'b1);
    checkOutput("abort_not_yet", 32'(bus.abort_o), 32'd0);
    idleCycles(1, 1'b1);
    checkOutput("abort_pulse", 32'(bus.abort_o), 32'd1);
    sendWord(4'hA, 1'b1);
    checkOutput("after_abort", 32'(bus.parallel_o), 32'hA);

    // Gap one short of the timeout keeps the partial word.
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    idleCycles(7, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("gap7_word", 32'(bus.parallel_o), 32'h6);
    idleCycles(1, 1'b1);

    // Asynchronous reset with a word buffered and a partial word in flight.
    sendWord(4'h5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("async_level", 32'(bus.level_o), 32'd0);
    modelReset();
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    sendWord(4'hC, 1'b1);
    checkOutput("post_reset_word", 32'(bus.parallel_o), 32'hC);

    // Randomized stream with occasional long gaps.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0)
        idleCycles(int'($urandom_range(5, 10)), $urandom_range(0, 2) != 0);
      else
        applyStimulus(1'($urandom), $urandom_range(0, 4) != 0,
                      $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
